ibex_trace_buffer: RTL and testbench

Parametrised retirement-trace capture buffer for the Ibex core. Taps the RVFI retirement stream beside the tracer and stores selected per-instruction records in an on-chip circular buffer. Supports arm/trigger/freeze capture control, stop-on-full or overwrite-oldest policies, and a ready/valid drain port, so a debug host or testbench can read the last N retirements around a PC trigger.

---
 rtl/ibex_trace_buffer.sv | 187 ++++++++++++++++++
 tb/tb_ibex_trace_buffer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_trace_buffer.sv
// Retirement-trace capture buffer: taps RVFI, stores records in a circular buffer
// with arm/trigger/freeze control. Optional IBEX_TRACE_TIMESTAMP_EN adds a cycle stamp per record.
module ibex_trace_buffer #(
  parameter int unsigned Depth         = 16,
  parameter bit          StopOnFull    = 1'b1,
  parameter int unsigned PostTrigCount = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        arm_i,
  input  logic        clear_i,
  input  logic        trig_en_i,
  input  logic [31:0] trig_pc_i,
  input  logic        rvfi_valid_i,
  input  logic [31:0] rvfi_pc_rdata_i,
  input  logic [31:0] rvfi_insn_i,
  input  logic [4:0]  rvfi_rd_addr_i,
  input  logic [31:0] rvfi_rd_wdata_i,
  input  logic        rvfi_trap_i,
  input  logic        rvfi_intr_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_pc_o,
  output logic [31:0] out_insn_o,
  output logic [31:0] out_rd_wdata_o,
  output logic [4:0]  out_rd_addr_o,
  output logic        out_trap_o,
  output logic        out_intr_o,
  output logic        out_trig_o,
  output logic [$clog2(Depth):0] level_o,
  output logic [15:0] drop_cnt_o,
`ifdef IBEX_TRACE_TIMESTAMP_EN
  output logic [31:0] out_cycle_o,
`endif
  output logic [1:0]  state_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_POST   = 2'd2,
    ST_FROZEN = 2'd3
  } state_e;

  typedef struct packed {
`ifdef IBEX_TRACE_TIMESTAMP_EN
    logic [31:0] cycle;
`endif
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic        intr;
    logic        trig;
  } rec_t;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_cnt_q, post_cnt_d;
  logic [LW-1:0] level_q, level_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  rec_t          mem_q [Depth];
  rec_t          mem_d [Depth];
  rec_t          rec_in, head;
  logic          capture, trig_hit, full, pop, wr_en, drop;

`ifdef IBEX_TRACE_TIMESTAMP_EN
  logic [31:0] cycle_q, cycle_d;
  assign cycle_d = cycle_q + 32'd1;
`endif

  // Output handshake: a record transfers when out_valid_o && out_ready_i on a rising edge;
  // head fields are held steady while out_valid_o is high and out_ready_i is low.
  assign out_valid_o = (level_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign full        = (level_q == LW'(Depth));
  assign capture     = rvfi_valid_i && ((state_q == ST_RUN) || (state_q == ST_POST));
  assign trig_hit    = (state_q == ST_RUN) && trig_en_i && rvfi_valid_i &&
                       (rvfi_pc_rdata_i == trig_pc_i);
  assign wr_en       = capture && (!full || pop || !StopOnFull);
  assign drop        = capture && full && !pop;

  always_comb begin
    rec_in          = '0;
`ifdef IBEX_TRACE_TIMESTAMP_EN
    rec_in.cycle    = cycle_q;
`endif
    rec_in.pc       = rvfi_pc_rdata_i;
    rec_in.insn     = rvfi_insn_i;
    rec_in.rd_addr  = rvfi_rd_addr_i;
    rec_in.rd_wdata = rvfi_rd_wdata_i;
    rec_in.trap     = rvfi_trap_i;
    rec_in.intr     = rvfi_intr_i;
    rec_in.trig     = trig_hit;
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    post_cnt_d = post_cnt_q;
    level_d    = level_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < int'(Depth); i++) mem_d[i] = mem_q[i];

    if (clear_i) begin
      state_d    = ST_IDLE;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      post_cnt_d = '0;
      level_d    = '0;
      drop_cnt_d = '0;
      for (int i = 0; i < int'(Depth); i++) mem_d[i] = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (arm_i) state_d = ST_RUN;
        ST_RUN: begin
          if (trig_hit) begin
            post_cnt_d = AW'(PostTrigCount);
            state_d    = (PostTrigCount == 0) ? ST_FROZEN : ST_POST;
          end
        end
        ST_POST: begin
          if (capture) begin
            post_cnt_d = post_cnt_q - AW'(1);
            if (post_cnt_q == AW'(1)) state_d = ST_FROZEN;
          end
        end
        default: state_d = ST_FROZEN;
      endcase

      if (wr_en) begin
        mem_d[wr_ptr_q] = rec_in;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      // Overwrite-oldest on a full buffer also pushes the read pointer past the lost record.
      if (pop || (wr_en && full)) rd_ptr_d = rd_ptr_q + AW'(1);
      if (wr_en && !full && !pop) level_d = level_q + LW'(1);
      else if (pop && !wr_en)     level_d = level_q - LW'(1);
      if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      post_cnt_q <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      post_cnt_q <= post_cnt_d;
      level_q    <= level_d;
      drop_cnt_q <= drop_cnt_d;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef IBEX_TRACE_TIMESTAMP_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) cycle_q <= '0;
    else       cycle_q <= cycle_d;
  end
  assign out_cycle_o = head.cycle;
`endif

  assign head           = mem_q[rd_ptr_q];
  assign out_pc_o       = head.pc;
  assign out_insn_o     = head.insn;
  assign out_rd_wdata_o = head.rd_wdata;
  assign out_rd_addr_o  = head.rd_addr;
  assign out_trap_o     = head.trap;
  assign out_intr_o     = head.intr;
  assign out_trig_o     = head.trig;
  assign level_o        = level_q;
  assign drop_cnt_o     = drop_cnt_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Directed bench for ibex_trace_buffer: three instances (Depth 16 stop-on-full, Depth 4
// stop-on-full, Depth 4 overwrite) share one stimulus stream; a scoreboard checks drained records.
module tb_ibex_trace_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        arm = 1'b0, clear = 1'b0, trig_en = 1'b0, out_ready = 1'b0;
  logic [31:0] trig_pc = '0;
  logic        rv_valid = 1'b0, rv_trap = 1'b0, rv_intr = 1'b0;
  logic [31:0] rv_pc = '0, rv_insn = '0, rv_wdata = '0;
  logic [4:0]  rv_rd = '0;

  logic        a_valid, b_valid, c_valid;
  logic [31:0] a_pc, b_pc, c_pc, a_insn, b_insn, c_insn, a_wdata, b_wdata, c_wdata;
  logic [4:0]  a_rd, b_rd, c_rd;
  logic        a_trap, b_trap, c_trap, a_intr, b_intr, c_intr, a_trig, b_trig, c_trig;
  logic [4:0]  a_level;
  logic [2:0]  b_level, c_level;
  logic [15:0] a_drop, b_drop, c_drop;
  logic [1:0]  a_state, b_state, c_state;
`ifdef IBEX_TRACE_TIMESTAMP_EN
  logic [31:0] a_cycle, b_cycle, c_cycle;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  ibex_trace_buffer #(.Depth(16), .StopOnFull(1'b1), .PostTrigCount(2)) u_a (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clear), .trig_en_i(trig_en),
    .trig_pc_i(trig_pc), .rvfi_valid_i(rv_valid), .rvfi_pc_rdata_i(rv_pc),
    .rvfi_insn_i(rv_insn), .rvfi_rd_addr_i(rv_rd), .rvfi_rd_wdata_i(rv_wdata),
    .rvfi_trap_i(rv_trap), .rvfi_intr_i(rv_intr), .out_valid_o(a_valid),
    .out_ready_i(out_ready), .out_pc_o(a_pc), .out_insn_o(a_insn),
    .out_rd_wdata_o(a_wdata), .out_rd_addr_o(a_rd), .out_trap_o(a_trap),
    .out_intr_o(a_intr), .out_trig_o(a_trig), .level_o(a_level), .drop_cnt_o(a_drop),
`ifdef IBEX_TRACE_TIMESTAMP_EN
    .out_cycle_o(a_cycle),
`endif
    .state_o(a_state)
  );

  ibex_trace_buffer #(.Depth(4), .StopOnFull(1'b1), .PostTrigCount(2)) u_b (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clear), .trig_en_i(trig_en),
    .trig_pc_i(trig_pc), .rvfi_valid_i(rv_valid), .rvfi_pc_rdata_i(rv_pc),
    .rvfi_insn_i(rv_insn), .rvfi_rd_addr_i(rv_rd), .rvfi_rd_wdata_i(rv_wdata),
    .rvfi_trap_i(rv_trap), .rvfi_intr_i(rv_intr), .out_valid_o(b_valid),
    .out_ready_i(out_ready), .out_pc_o(b_pc), .out_insn_o(b_insn),
    .out_rd_wdata_o(b_wdata), .out_rd_addr_o(b_rd), .out_trap_o(b_trap),
    .out_intr_o(b_intr), .out_trig_o(b_trig), .level_o(b_level), .drop_cnt_o(b_drop),
`ifdef IBEX_TRACE_TIMESTAMP_EN
    .out_cycle_o(b_cycle),
`endif
    .state_o(b_state)
  );

  ibex_trace_buffer #(.Depth(4), .StopOnFull(1'b0), .PostTrigCount(2)) u_c (
    .clk_i(clk), .rst_i(rst), .arm_i(arm), .clear_i(clear), .trig_en_i(trig_en),
    .trig_pc_i(trig_pc), .rvfi_valid_i(rv_valid), .rvfi_pc_rdata_i(rv_pc),
    .rvfi_insn_i(rv_insn), .rvfi_rd_addr_i(rv_rd), .rvfi_rd_wdata_i(rv_wdata),
    .rvfi_trap_i(rv_trap), .rvfi_intr_i(rv_intr), .out_valid_o(c_valid),
    .out_ready_i(out_ready), .out_pc_o(c_pc), .out_insn_o(c_insn),
    .out_rd_wdata_o(c_wdata), .out_rd_addr_o(c_rd), .out_trap_o(c_trap),
    .out_intr_o(c_intr), .out_trig_o(c_trig), .level_o(c_level), .drop_cnt_o(c_drop),
`ifdef IBEX_TRACE_TIMESTAMP_EN
    .out_cycle_o(c_cycle),
`endif
    .state_o(c_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One retirement in one cycle; insn/wdata/rd are derived from the PC so they can be predicted.
  task automatic retire(input logic [31:0] pc, input logic trap, input logic intr);
    rv_valid = 1'b1;
    rv_pc    = pc;
    rv_insn  = ~pc;
    rv_wdata = pc + 32'd1;
    rv_rd    = pc[8:4];
    rv_trap  = trap;
    rv_intr  = intr;
    tick();
    rv_valid = 1'b0;
    rv_trap  = 1'b0;
    rv_intr  = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic trap, input logic intr, input logic trig);
    exp_q.push_back({intr, trap, trig, pc});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  function automatic logic [34:0] obs_rec(input int sel);
    case (sel)
      0:       return {a_intr, a_trap, a_trig, a_pc};
      1:       return {b_intr, b_trap, b_trig, b_pc};
      default: return {c_intr, c_trap, c_trig, c_pc};
    endcase
  endfunction

  function automatic logic obs_valid(input int sel);
    case (sel)
      0:       return a_valid;
      1:       return b_valid;
      default: return c_valid;
    endcase
  endfunction

  // Hold ready high for n cycles; each cycle the head of instance sel must match the queue front.
  task automatic drain(input int sel, input int n);
    logic [34:0] exp;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check($sformatf("drain%0d_valid[%0d]", sel, i), 35'(obs_valid(sel)), 35'd1);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL drain%0d_queue: observed=empty expected=record", sel);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("drain%0d_rec[%0d]", sel, i), obs_rec(sel), exp);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  initial begin
`ifdef IBEX_TRACE_TIMESTAMP_EN
    logic [31:0] c0;
`endif
    // Reset values
    rst = 1'b1;
    tick();
    tick();
    check("rst_level", 35'(a_level), 35'd0);
    check("rst_drop", 35'(a_drop), 35'd0);
    check("rst_state", 35'(a_state), 35'd0);
    check("rst_valid", 35'(a_valid), 35'd0);
    check("rst_rec", obs_rec(0), 35'd0);
    rst = 1'b0;
    tick();

    // Basic capture and in-order drain
    pulse_arm();
    check("arm_state", 35'(a_state), 35'd1);
    retire(32'h100, 1'b0, 1'b0); push(32'h100, 1'b0, 1'b0, 1'b0);
    retire(32'h104, 1'b1, 1'b0); push(32'h104, 1'b1, 1'b0, 1'b0);
    retire(32'h108, 1'b0, 1'b1); push(32'h108, 1'b0, 1'b1, 1'b0);
    check("basic_level", 35'(a_level), 35'd3);
    check("basic_insn", 35'(a_insn), 35'(32'hFFFF_FEFF));
    check("basic_wdata", 35'(a_wdata), 35'(32'h101));
    check("basic_rd", 35'(a_rd), 35'(5'h10));
    tick();
    check("basic_hold_pc", 35'(a_pc), 35'(32'h100));
    drain(0, 3);
    check("basic_empty_level", 35'(a_level), 35'd0);
    check("basic_empty_valid", 35'(a_valid), 35'd0);

    // Depth 4 full: stop-on-full (b) vs overwrite-oldest (c)
    pulse_clear();
    pulse_arm();
    for (int i = 0; i < 6; i++) retire(32'h300 + 32'(4 * i), 1'b0, 1'b0);
    check("sof_level", 35'(b_level), 35'd4);
    check("sof_drop", 35'(b_drop), 35'd2);
    check("sof_head", 35'(b_pc), 35'(32'h300));
    check("ovw_level", 35'(c_level), 35'd4);
    check("ovw_drop", 35'(c_drop), 35'd2);
    for (int i = 2; i < 6; i++) push(32'h300 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
    drain(2, 4);
    check("ovw_empty_level", 35'(c_level), 35'd0);

    // Full buffer with capture and pop together
    pulse_clear();
    pulse_arm();
    for (int i = 0; i < 4; i++) retire(32'h400 + 32'(4 * i), 1'b0, 1'b0);
    check("cp_full_level", 35'(b_level), 35'd4);
    out_ready = 1'b1;
    retire(32'h410, 1'b0, 1'b0);
    out_ready = 1'b0;
    check("cp_level", 35'(b_level), 35'd4);
    check("cp_drop", 35'(b_drop), 35'd0);
    check("cp_head", 35'(b_pc), 35'(32'h404));
    check("cp_ovw_drop", 35'(c_drop), 35'd0);

    // PC trigger with two post-trigger records
    pulse_clear();
    pulse_arm();
    trig_en = 1'b1;
    trig_pc = 32'h200;
    retire(32'h1F8, 1'b0, 1'b0); push(32'h1F8, 1'b0, 1'b0, 1'b0);
    check("trig_state_run", 35'(a_state), 35'd1);
    retire(32'h1FC, 1'b0, 1'b0); push(32'h1FC, 1'b0, 1'b0, 1'b0);
    retire(32'h200, 1'b0, 1'b0); push(32'h200, 1'b0, 1'b0, 1'b1);
    check("trig_state_post", 35'(a_state), 35'd2);
    retire(32'h204, 1'b0, 1'b0); push(32'h204, 1'b0, 1'b0, 1'b0);
    check("trig_state_post2", 35'(a_state), 35'd2);
    retire(32'h208, 1'b0, 1'b0); push(32'h208, 1'b0, 1'b0, 1'b0);
    check("trig_state_frozen", 35'(a_state), 35'd3);
    retire(32'h20C, 1'b0, 1'b0);
    retire(32'h210, 1'b0, 1'b0);
    check("trig_level", 35'(a_level), 35'd5);
    drain(0, 5);
    check("trig_frozen_after_drain", 35'(a_state), 35'd3);

    // Clear beats arm, capture and pop in the same cycle while frozen
    pulse_clear();
    pulse_arm();
    trig_pc = 32'h500;
    retire(32'h4F0, 1'b0, 1'b0);
    retire(32'h4F4, 1'b0, 1'b0);
    retire(32'h500, 1'b0, 1'b0);
    retire(32'h504, 1'b0, 1'b0);
    retire(32'h508, 1'b0, 1'b0);
    retire(32'h50C, 1'b0, 1'b0);
    check("frz_state", 35'(a_state), 35'd3);
    check("frz_level", 35'(a_level), 35'd5);
    check("frz_b_drop", 35'(b_drop), 35'd1);
    clear     = 1'b1;
    arm       = 1'b1;
    out_ready = 1'b1;
    retire(32'h510, 1'b0, 1'b0);
    clear     = 1'b0;
    arm       = 1'b0;
    out_ready = 1'b0;
    trig_en   = 1'b0;
    check("clr_level", 35'(a_level), 35'd0);
    check("clr_state", 35'(a_state), 35'd0);
    check("clr_valid", 35'(a_valid), 35'd0);
    check("clr_rec", obs_rec(0), 35'd0);
    check("clr_b_drop", 35'(b_drop), 35'd0);

    // Arm ignored outside IDLE: a second arm while RUN keeps RUN
    pulse_arm();
    pulse_arm();
    check("rearm_state", 35'(a_state), 35'd1);

`ifdef IBEX_TRACE_TIMESTAMP_EN
    pulse_clear();
    pulse_arm();
    retire(32'h600, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    retire(32'h604, 1'b0, 1'b0);
    c0 = a_cycle;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ts_pc", 35'(a_pc), 35'(32'h604));
    check("ts_delta", 35'(a_cycle - c0), 35'd5);
`endif

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL queue_leftover: observed=%0d expected=0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
